// File: rtl/store_buffer_pkg.sv
// Shared types for the committed-store buffer: load/store width encoding,
// buffer entry layout and geometry.
package store_buffer_pkg;

   localparam int SB_DEPTH_LOG = 3;
   localparam int SB_DEPTH     = 2**SB_DEPTH_LOG;
   localparam int NUM_LANES    = 2;

   typedef logic bool;
   localparam bool true  = 1'b1;
   localparam bool false = 1'b0;

   typedef enum logic [1:0] {
      LDST_BYTE = 2'b00,
      LDST_HALF = 2'b01,
      LDST_WORD = 2'b10
   } ldst_mode_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      ldst_mode_t  mode;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Per-load-port forwarding search: walks from the youngest entry (tail-1)
// back to head and reports on the first word-address match.
module sb_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH_LOG = SB_DEPTH_LOG
) (
   input  sb_entry_t                 ents [2**DEPTH_LOG],
   input  logic [2**DEPTH_LOG-1:0]   vld,
   input  logic [DEPTH_LOG-1:0]      head,
   input  logic [DEPTH_LOG-1:0]      tail,
   input  logic [31:0]               ld_addr,
   input  ldst_mode_t                ld_mode,
   output logic                      hit,
   output logic                      conflict,
   output logic [31:0]               data
);

   localparam int DEPTH = 2**DEPTH_LOG;

   logic [DEPTH_LOG-1:0] idx;
   logic                 found;
   logic                 done;
   logic                 unused_bits;

   always_comb begin
      hit      = false;
      conflict = false;
      data     = '0;
      found    = false;
      done     = false;
      idx      = tail;
      for (int k = 0; k < DEPTH; k++) begin
         idx = tail - DEPTH_LOG'(k + 1);
         if (!found && !done && vld[idx] && ents[idx].addr[31:2] == ld_addr[31:2]) begin
            found = true;
            // Only a full word over a full word can be forwarded safely.
            if (ents[idx].mode == LDST_WORD && ld_mode == LDST_WORD) begin
               hit  = true;
               data = ents[idx].data;
            end else begin
               conflict = true;
            end
         end
         if (idx == head) done = true;
      end
   end

   always_comb begin
      unused_bits = ^ld_addr[1:0];
      for (int i = 0; i < DEPTH; i++) unused_bits = unused_bits ^ (^ents[i].addr[1:0]);
   end

endmodule

// File: rtl/store_buffer.sv
// Committed-store queue: 2 stores/cycle in from commit, 1 store/cycle out
// to the dmem write port, with youngest-match forwarding to both load ports.
module store_buffer
   import store_buffer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            st_valid,
   input  logic [1:0][31:0]      st_addr,
   input  logic [1:0][31:0]      st_data,
   input  ldst_mode_t [1:0]      st_mode,
   output logic                  st_ready,
   output logic                  mem_we,
   output logic [31:0]           mem_wa,
   output logic [31:0]           mem_wd,
   output ldst_mode_t            mem_wm,
   input  logic [1:0][31:0]      ld_addr,
   input  ldst_mode_t [1:0]      ld_mode,
   output logic [1:0]            ld_hit,
   output logic [1:0][31:0]      ld_data,
   output logic [1:0]            ld_conflict,
   output logic                  empty
);

   localparam int CW = SB_DEPTH_LOG + 1;

   sb_entry_t               ents [SB_DEPTH];
   logic [SB_DEPTH_LOG-1:0] head;
   logic [SB_DEPTH_LOG-1:0] tail;
   logic [CW-1:0]           count;
   logic [SB_DEPTH_LOG-1:0] off;
   logic [SB_DEPTH-1:0]     vld;
   logic [1:0]              enq;
   logic [CW-1:0]           enq_cnt;
   logic                    drain;

   assign drain    = (count != '0);
   // Ignores the same-cycle drain so ready never depends on this cycle's inputs.
   assign st_ready = (count <= CW'(SB_DEPTH - 2));
   assign enq      = st_valid & {NUM_LANES{st_ready}};
   assign enq_cnt  = CW'(enq[0]) + CW'(enq[1]);

   always_comb begin
      off = '0;
      vld = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         off    = SB_DEPTH_LOG'(i) - head;
         vld[i] = ({1'b0, off} < count);
      end
   end

   // Payloads are not reset; validity comes only from head/count.
   always_ff @(posedge clk) begin
      if (enq[0])
         ents[tail] <= '{addr: st_addr[0], data: st_data[0], mode: st_mode[0]};
      if (enq[1])
         ents[enq[0] ? tail + SB_DEPTH_LOG'(1) : tail] <=
            '{addr: st_addr[1], data: st_data[1], mode: st_mode[1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + SB_DEPTH_LOG'(drain);
         tail  <= tail + SB_DEPTH_LOG'(enq_cnt);
         count <= count + enq_cnt - CW'(drain);
      end
   end

   assign mem_we = drain;
   assign mem_wa = ents[head].addr;
   assign mem_wd = ents[head].data;
   assign mem_wm = ents[head].mode;
   assign empty  = !drain;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_ld
      sb_match #(.DEPTH_LOG(SB_DEPTH_LOG)) u_match (
         .ents     (ents),
         .vld      (vld),
         .head     (head),
         .tail     (tail),
         .ld_addr  (ld_addr[g]),
         .ld_mode  (ld_mode[g]),
         .hit      (ld_hit[g]),
         .conflict (ld_conflict[g]),
         .data     (ld_data[g])
      );
   end

   a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
      !(|st_valid && !st_ready));

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued as
// stores are issued and popped as the write port fires.
module tb_store_buffer;
   import store_buffer_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       st_valid;
   logic [1:0][31:0] st_addr;
   logic [1:0][31:0] st_data;
   ldst_mode_t [1:0] st_mode;
   logic             st_ready;
   logic             mem_we;
   logic [31:0]      mem_wa;
   logic [31:0]      mem_wd;
   ldst_mode_t       mem_wm;
   logic [1:0][31:0] ld_addr;
   ldst_mode_t [1:0] ld_mode;
   logic [1:0]       ld_hit;
   logic [1:0][31:0] ld_data;
   logic [1:0]       ld_conflict;
   logic             empty;

   int        checks = 0;
   int        errors = 0;
   sb_entry_t exp_q[$];
   int        exp_cnt = 0;
   logic      pend = 1'b0;
   sb_entry_t pend_e;

   always #5 clk = ~clk;

   store_buffer dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode),
      .st_ready(st_ready),
      .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_wm(mem_wm),
      .ld_addr(ld_addr), .ld_mode(ld_mode),
      .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
      .empty(empty)
   );

   // Memory side: a write seen at negedge lands at the next posedge unless reset intervenes.
   always @(negedge clk) begin
      pend   = rst_n && mem_we;
      pend_e = '{addr: mem_wa, data: mem_wd, mode: mem_wm};
   end

   always @(posedge clk) begin
      if (pend && rst_n) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mem_write unexpected wa=%h wd=%h", pend_e.addr, pend_e.data);
         end else begin
            sb_entry_t e;
            e = exp_q.pop_front();
            if (pend_e !== e) begin
               errors++;
               $display("FAIL mem_write got wa=%h wd=%h wm=%0d want wa=%h wd=%h wm=%0d",
                        pend_e.addr, pend_e.data, pend_e.mode, e.addr, e.data, e.mode);
            end
         end
      end
   end

   task automatic cyc(input logic [1:0] v,
                      input logic [31:0] a0, input logic [31:0] d0, input ldst_mode_t m0,
                      input logic [31:0] a1, input logic [31:0] d1, input ldst_mode_t m1);
      logic [1:0] e;
      e = st_ready ? v : 2'b00;
      st_valid   = e;
      st_addr[0] = a0; st_data[0] = d0; st_mode[0] = m0;
      st_addr[1] = a1; st_data[1] = d1; st_mode[1] = m1;
      if (e[0]) exp_q.push_back('{addr: a0, data: d0, mode: m0});
      if (e[1]) exp_q.push_back('{addr: a1, data: d1, mode: m1});
      @(posedge clk);
      exp_cnt = exp_cnt + int'(e[0]) + int'(e[1]) - int'(exp_cnt != 0);
      @(negedge clk);
      st_valid = 2'b00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         exp_cnt = exp_cnt - int'(exp_cnt != 0);
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n      = 1'b0;
      st_valid   = 2'b11;
      st_addr[0] = 32'h0000_0200; st_data[0] = 32'hDEAD_0000; st_mode[0] = LDST_WORD;
      st_addr[1] = 32'h0000_0204; st_data[1] = 32'hDEAD_0001; st_mode[1] = LDST_WORD;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
      checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b want 1", st_ready); end
      checks++; if (ld_hit !== 2'b00 || ld_conflict !== 2'b00)
         begin errors++; $display("FAIL reset_ld got hit=%b conf=%b want 00 00", ld_hit, ld_conflict); end
      st_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (empty !== 1'b1 || mem_we !== 1'b0)
         begin errors++; $display("FAIL post_reset got empty=%b we=%b want 1 0", empty, mem_we); end
   endtask

   task automatic test_dual_enqueue;
      cyc(2'b11, 32'h10, 32'hAAAA_0001, LDST_WORD, 32'h14, 32'hBBBB_0002, LDST_WORD);
      checks++; if (mem_we !== 1'b1 || mem_wa !== 32'h10)
         begin errors++; $display("FAIL dual_first got we=%b wa=%h want 1 00000010", mem_we, mem_wa); end
      idle(1);
      checks++; if (mem_we !== 1'b1 || mem_wa !== 32'h14)
         begin errors++; $display("FAIL dual_second got we=%b wa=%h want 1 00000014", mem_we, mem_wa); end
      idle(1);
      checks++; if (mem_we !== 1'b0 || empty !== 1'b1)
         begin errors++; $display("FAIL dual_done got we=%b empty=%b want 0 1", mem_we, empty); end
      checks++; if (exp_q.size() != 0)
         begin errors++; $display("FAIL dual_sb got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_full_wrap;
      int   issued;
      logic saw_stall;
      logic want_rdy;
      issued    = 0;
      saw_stall = 1'b0;
      for (int c = 0; c < 100 && issued < 20; c++) begin
         want_rdy = ((SB_DEPTH - exp_cnt) >= 2);
         checks++; if (st_ready !== want_rdy)
            begin errors++; $display("FAIL full_ready cnt=%0d got %b want %b", exp_cnt, st_ready, want_rdy); end
         if (!st_ready) saw_stall = 1'b1;
         if (st_ready)
            cyc(2'b11, 32'h100 + 32'(8*issued), 32'hC0DE_0000 + 32'(issued), LDST_WORD,
                32'h104 + 32'(8*issued), 32'hC0DE_0001 + 32'(issued), LDST_WORD);
         else
            idle(1);
         if (st_ready || issued < 20) issued = issued + (want_rdy ? 2 : 0);
      end
      checks++; if (saw_stall !== 1'b1)
         begin errors++; $display("FAIL full_stall got %b want 1", saw_stall); end
      for (int c = 0; c < 50 && !empty; c++) idle(1);
      checks++; if (empty !== 1'b1 || exp_q.size() != 0)
         begin errors++; $display("FAIL full_drain got empty=%b pending=%0d want 1 0", empty, exp_q.size()); end
   endtask

   task automatic test_forward;
      cyc(2'b11, 32'h20, 32'h1111_1111, LDST_WORD, 32'h20, 32'h2222_2222, LDST_WORD);
      ld_addr[0] = 32'h20; ld_mode[0] = LDST_WORD;
      ld_addr[1] = 32'h20; ld_mode[1] = LDST_WORD;
      #1;
      checks++; if (ld_hit !== 2'b11 || ld_conflict !== 2'b00)
         begin errors++; $display("FAIL fwd_hit got hit=%b conf=%b want 11 00", ld_hit, ld_conflict); end
      checks++; if (ld_data[0] !== 32'h2222_2222 || ld_data[1] !== 32'h2222_2222)
         begin errors++; $display("FAIL fwd_youngest got %h %h want 22222222", ld_data[0], ld_data[1]); end
      ld_addr[1] = 32'h24;
      #1;
      checks++; if (ld_hit[1] !== 1'b0 || ld_conflict[1] !== 1'b0)
         begin errors++; $display("FAIL fwd_nomatch got hit=%b conf=%b want 0 0", ld_hit[1], ld_conflict[1]); end
      idle(1);
      #1;
      checks++; if (ld_hit[0] !== 1'b1 || ld_data[0] !== 32'h2222_2222)
         begin errors++; $display("FAIL fwd_head got hit=%b data=%h want 1 22222222", ld_hit[0], ld_data[0]); end
      idle(1);
      cyc(2'b10, 32'h0, 32'h0, LDST_WORD, 32'h50, 32'h5555_0050, LDST_WORD);
      ld_addr[0] = 32'h50;
      #1;
      checks++; if (mem_wa !== 32'h50 || ld_hit[0] !== 1'b1 || ld_data[0] !== 32'h5555_0050)
         begin errors++; $display("FAIL fwd_lane1 got wa=%h hit=%b data=%h want 00000050 1 55550050", mem_wa, ld_hit[0], ld_data[0]); end
      idle(1);
      checks++; if (empty !== 1'b1 || exp_q.size() != 0)
         begin errors++; $display("FAIL fwd_drain got empty=%b pending=%0d want 1 0", empty, exp_q.size()); end
   endtask

   task automatic test_conflict;
      cyc(2'b01, 32'h23, 32'h0000_00AB, LDST_BYTE, 32'h0, 32'h0, LDST_WORD);
      ld_addr[0] = 32'h20; ld_mode[0] = LDST_WORD;
      ld_addr[1] = 32'h23; ld_mode[1] = LDST_BYTE;
      #1;
      checks++; if (ld_conflict !== 2'b11 || ld_hit !== 2'b00)
         begin errors++; $display("FAIL conf_byte got conf=%b hit=%b want 11 00", ld_conflict, ld_hit); end
      idle(1);
      #1;
      checks++; if (ld_conflict !== 2'b00 || ld_hit !== 2'b00)
         begin errors++; $display("FAIL conf_drained got conf=%b hit=%b want 00 00", ld_conflict, ld_hit); end
      cyc(2'b11, 32'h60, 32'h6060_6060, LDST_WORD, 32'h61, 32'h0000_0061, LDST_BYTE);
      ld_addr[0] = 32'h60; ld_mode[0] = LDST_WORD;
      ld_addr[1] = 32'h30; ld_mode[1] = LDST_WORD;
      #1;
      checks++; if (ld_conflict[0] !== 1'b1 || ld_hit[0] !== 1'b0)
         begin errors++; $display("FAIL conf_young_byte got conf=%b hit=%b want 1 0", ld_conflict[0], ld_hit[0]); end
      idle(2);
      cyc(2'b11, 32'h70, 32'h0000_0070, LDST_BYTE, 32'h70, 32'h7070_7070, LDST_WORD);
      ld_addr[0] = 32'h70; ld_mode[0] = LDST_WORD;
      ld_addr[1] = 32'h71; ld_mode[1] = LDST_BYTE;
      #1;
      checks++; if (ld_hit[0] !== 1'b1 || ld_data[0] !== 32'h7070_7070 || ld_conflict[0] !== 1'b0)
         begin errors++; $display("FAIL conf_young_word got hit=%b data=%h conf=%b want 1 70707070 0", ld_hit[0], ld_data[0], ld_conflict[0]); end
      checks++; if (ld_conflict[1] !== 1'b1 || ld_hit[1] !== 1'b0)
         begin errors++; $display("FAIL conf_subword_load got conf=%b hit=%b want 1 0", ld_conflict[1], ld_hit[1]); end
      idle(2);
      ld_addr[0] = 32'hFFFF_FFF0; ld_addr[1] = 32'hFFFF_FFF0;
      checks++; if (empty !== 1'b1 || exp_q.size() != 0)
         begin errors++; $display("FAIL conf_drain got empty=%b pending=%0d want 1 0", empty, exp_q.size()); end
   endtask

   task automatic test_reset_mid_drain;
      cyc(2'b11, 32'h80, 32'h8000_0080, LDST_WORD, 32'h84, 32'h8000_0084, LDST_WORD);
      cyc(2'b11, 32'h88, 32'h8000_0088, LDST_WORD, 32'h8C, 32'h8000_008C, LDST_WORD);
      checks++; if (mem_we !== 1'b1 || mem_wa !== 32'h84)
         begin errors++; $display("FAIL mid_pre got we=%b wa=%h want 1 00000084", mem_we, mem_wa); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1)
         begin errors++; $display("FAIL mid_reset got we=%b empty=%b rdy=%b want 0 1 1", mem_we, empty, st_ready); end
      exp_q.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      checks++; if (mem_we !== 1'b0 || empty !== 1'b1)
         begin errors++; $display("FAIL mid_after got we=%b empty=%b want 0 1", mem_we, empty); end
   endtask

   initial begin
      st_valid = 2'b00;
      st_addr  = '0;
      st_data  = '0;
      st_mode  = {LDST_WORD, LDST_WORD};
      ld_addr  = {32'hFFFF_FFF0, 32'hFFFF_FFF0};
      ld_mode  = {LDST_WORD, LDST_WORD};
      test_reset();
      test_dual_enqueue();
      test_full_wrap();
      test_forward();
      test_conflict();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
